imem_block_responder: RTL
=========================

Name: imem_block_responder

Overview:
- Instruction-memory side of the I-cache refill interface: answers 16-byte block read requests from the instruction cache using the read / busywait / 128-bit block handshake.
- Holds 1024 bytes of program storage, organised as 64 blocks of 16 bytes.
- Inserts a programmable multi-cycle latency on each read.
- Has a byte-wide load port the testbench or boot logic uses to preload the program.

Parameters:
- LATENCY, 4, number of cycles spent in BUSY per read; legal range 1..255.
- CNT_W, 8, width of the latency counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- read  in  1  block read request from the cache; held high until the cache sees busywait low.
- address  in  6  block address {tag[2:0], index[2:0]}.
- busywait  out  1  high while a request is being serviced.
- readinst  out  128  returned block.
- load_en  in  1  program-load byte write strobe.
- load_addr  in  10  byte address for the load.
- load_byte  in  8  byte data for the load.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, counter=0, busywait=0, readinst=0. Storage contents are NOT cleared. Reset asserted mid-read aborts the transaction immediately; no data is returned.
- Block layout: block a occupies bytes 16a..16a+15. Byte 16a+i maps to readinst[8i+7:8i], so instruction word k (offset k) is readinst[32k+31:32k] (little-endian).
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - busywait = read, combinationally, so the cache sees busywait high in the same cycle it raises read.
  - On a clock edge with read=1: latch address into addr_q, counter <= LATENCY-1, go to BUSY.
- BUSY:
  - busywait=1.
  - Each edge: if read=0, abort to IDLE, readinst unchanged.
  - Else if counter==0: readinst <= block[addr_q], go to DONE.
  - Else decrement counter.
- DONE:
  - busywait=0 for exactly one cycle; readinst stable and valid.
  - read is ignored in this state; this is the cycle the cache captures the block and drops read.
  - Next edge: go to IDLE.
- A read held high through DONE starts a new transaction on the following IDLE cycle. This gives back-to-back service.
- Latency: busywait is high for exactly LATENCY+1 consecutive cycles per request (the request cycle plus LATENCY BUSY cycles), then low in DONE.
- readinst only changes on the completion edge or on reset; it holds its value otherwise.
- address changes after acceptance are ignored (addr_q is used).
- Block data is sampled at the completion edge.
- Load port:
  - Synchronous byte write on any edge with load_en=1, in any state.
  - A load to the block being read before the completion edge is visible in the returned data; a load on the completion edge itself is not.
  - load_addr uses the full 10-bit range; no out-of-range case exists.
- No wrap or overflow cases: the counter only counts down from LATENCY-1 to 0.

Decomposition:
- Shared package (imem_pkg):
  - state encoding IDLE=2'd0, BUSY=2'd1, DONE=2'd2;
  - BLOCK_BYTES=16, MEM_BYTES=1024, BLOCK_ADDR_W=6.
- One sub-module: imem_byte_array, a 1024x8 storage with a 1-byte synchronous write port and a 128-bit combinational block read port indexed by a 6-bit block address.
- The FSM, counter and output register live in the top module.

Test Plan:
- Preload bytes 0x010..0x01F with 0x00..0x0F; read=1, address=6'd1, LATENCY=4 -> busywait high for 5 cycles, then low one cycle with readinst=128'h0F0E0D0C_0B0A0908_07060504_03020100; word offset 2 = 32'h0B0A0908.
- Change address from 1 to 6'd5 two cycles after acceptance -> returned block is still block 1, with the same latency.
- Hold read high through DONE with address=6'd63 (bytes preloaded 0xFF) -> second transaction begins immediately; busywait 5 cycles, then readinst all ones.
- Assert reset asynchronously (mid-cycle) during the third BUSY cycle -> busywait and readinst go to 0 at once, state IDLE; a re-read of block 1 returns the preloaded data (storage retained).
- Drop read during BUSY -> next edge returns to IDLE with busywait=0; readinst retains its previous value.
- Write load_byte=0xAA to byte 0x010 during the second BUSY cycle of a read of block 1 -> readinst[7:0]=8'hAA.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared constants for the instruction-memory block responder:
// FSM encoding and storage geometry.
package imem_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int BLOCK_BYTES  = 16;
    localparam int MEM_BYTES    = 1024;
    localparam int BLOCK_ADDR_W = 6;
    localparam int BYTE_ADDR_W  = 10;
    localparam int BLOCK_W      = BLOCK_BYTES * 8;

endpackage

// File: rtl/imem_byte_array.sv
// 1024x8 program storage: synchronous byte write, combinational 128-bit block read.
// Contents have no reset so a preloaded program survives a core reset.
module imem_byte_array
    import imem_pkg::*;
(
    input  logic                    clock,
    input  logic                    wr_en,
    input  logic [BYTE_ADDR_W-1:0]  wr_addr,
    input  logic [7:0]              wr_byte,
    input  logic [BLOCK_ADDR_W-1:0] rd_blk,
    output logic [BLOCK_W-1:0]      rd_dat
);

    logic [7:0] mem_q [MEM_BYTES];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_byte;
        end
    end

    // Byte 16a+i lands in lane i, giving little-endian instruction words.
    always_comb begin
        rd_dat = '0;
        for (int i = 0; i < BLOCK_BYTES; i++) begin
            rd_dat[8*i +: 8] = mem_q[{rd_blk, 4'(i)}];
        end
    end

endmodule

// File: rtl/imem_block_responder.sv
// I-cache refill responder: read/busywait handshake with LATENCY BUSY cycles per block,
// one DONE cycle with busywait low, and a byte load port for program preload.
module imem_block_responder
    import imem_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int CNT_W   = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    read,
    input  logic [BLOCK_ADDR_W-1:0] address,
    output logic                    busywait,
    output logic [BLOCK_W-1:0]      readinst,
    input  logic                    load_en,
    input  logic [BYTE_ADDR_W-1:0]  load_addr,
    input  logic [7:0]              load_byte
);

    logic [1:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BLOCK_ADDR_W-1:0] addr_q, addr_d;
    logic [BLOCK_W-1:0]      readinst_q, readinst_d;
    logic [BLOCK_W-1:0]      blk_dat;
    logic                    busywait_c;

    imem_byte_array u_array (
        .clock   (clock),
        .wr_en   (load_en),
        .wr_addr (load_addr),
        .wr_byte (load_byte),
        .rd_blk  (addr_q),
        .rd_dat  (blk_dat)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        readinst_d = readinst_q;
        busywait_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Combinational so the cache stalls in the same cycle it raises read.
                busywait_c = read;
                if (read) begin
                    addr_d  = address;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                busywait_c = 1'b1;
                if (!read) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    readinst_d = blk_dat;
                    state_d    = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            readinst_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            readinst_q <= readinst_d;
        end
    end

    // Reset forces busywait low even if the cache is still holding read.
    assign busywait = busywait_c & ~reset;
    assign readinst = readinst_q;

endmodule
